// File: rtl/simmem_delay_releaser.sv
// Per-request delay tracker: each accepted request holds a slot until its delay matures and one bank response retires it.
// release_en_o rises D+1 cycles after acceptance; req_ready_o drops only when every slot is occupied.
module simmem_delay_releaser #(
  parameter int unsigned IDWidth    = 8,
  parameter int unsigned NumSlots   = 32,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [IDWidth-1:0]            req_id_i,
  input  logic [DelayWidth-1:0]         req_delay_i,
  output logic [2**IDWidth-1:0]         release_en_o,
  input  logic                          rsp_valid_i,
  input  logic                          rsp_ready_i,
  input  logic [IDWidth-1:0]            rsp_id_i,
  output logic [$clog2(NumSlots+1)-1:0] outstanding_o,
  output logic                          err_o
);

  localparam int unsigned OutW = $clog2(NumSlots + 1);

  logic [NumSlots-1:0]   valid_q;
  logic [IDWidth-1:0]    id_q  [NumSlots];
  logic [DelayWidth-1:0] cnt_q [NumSlots];
  logic                  err_q;

  logic [NumSlots-1:0]   free_vec;
  logic [NumSlots-1:0]   alloc_oh;
  logic [NumSlots-1:0]   matured;
  logic [NumSlots-1:0]   ret_cand;
  logic [NumSlots-1:0]   ret_oh;
  logic                  alloc;
  logic                  rsp_fire;
  logic                  ret_hit;

  // Lowest set bit isolated with x & -x; both searches look only at registered state.
  assign free_vec    = ~valid_q;
  assign alloc_oh    = free_vec & (~free_vec + NumSlots'(1));
  assign req_ready_o = |free_vec;
  assign alloc       = req_valid_i & req_ready_o;

  always_comb begin
    matured  = '0;
    ret_cand = '0;
    for (int i = 0; i < NumSlots; i++) begin
      matured[i]  = valid_q[i] && (cnt_q[i] == '0);
      ret_cand[i] = matured[i] && (id_q[i] == rsp_id_i);
    end
  end

  assign ret_oh   = ret_cand & (~ret_cand + NumSlots'(1));
  assign ret_hit  = |ret_cand;
  assign rsp_fire = rsp_valid_i & rsp_ready_i;

  // A retiring slot is valid, an allocated slot is not, so the two one-hots never overlap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (alloc && alloc_oh[i]) begin
          valid_q[i] <= 1'b1;
          id_q[i]    <= req_id_i;
          cnt_q[i]   <= req_delay_i;
        end else if (rsp_fire && ret_oh[i]) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
        end
      end
      if (rsp_fire && !ret_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    release_en_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (matured[i]) begin
        release_en_o[id_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (valid_q[i]) begin
        outstanding_o = outstanding_o + OutW'(1);
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Bench for simmem_delay_releaser: token-list model checked every cycle, plus literal spot checks.
module tb_simmem_delay_releaser;

  localparam int IDW = 8;
  localparam int NS  = 32;
  localparam int DW  = 8;
  localparam int OW  = $clog2(NS + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [IDW-1:0]  req_id_i = '0;
  logic [DW-1:0]   req_delay_i = '0;
  logic [255:0]    release_en_o;
  logic            rsp_valid_i = 1'b0;
  logic            rsp_ready_i = 1'b0;
  logic [IDW-1:0]  rsp_id_i = '0;
  logic [OW-1:0]   outstanding_o;
  logic            err_o;

  int checks = 0;
  int errors = 0;

  simmem_delay_releaser #(.IDWidth(IDW), .NumSlots(NS), .DelayWidth(DW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_id_i      (req_id_i),
    .req_delay_i   (req_delay_i),
    .release_en_o  (release_en_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_id_i      (rsp_id_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: a token is released once the edge count reaches its due edge (accept edge + 1 + delay).
  typedef struct {
    int id;
    int due;
  } tok_t;

  tok_t toks[$];
  int   e_cnt;
  bit   m_err;
  bit   m_ready;
  int   m_hit;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toks.delete();
      m_err = 1'b0;
      e_cnt = 0;
    end else begin
      m_ready = (toks.size() < NS);
      if (rsp_valid_i && rsp_ready_i) begin
        m_hit = -1;
        for (int j = 0; j < toks.size(); j++) begin
          if (m_hit < 0 && toks[j].id == int'(rsp_id_i) && toks[j].due <= e_cnt) m_hit = j;
        end
        if (m_hit >= 0) toks.delete(m_hit);
        else m_err = 1'b1;
      end
      if (req_valid_i && m_ready) begin
        toks.push_back('{id: int'(req_id_i), due: e_cnt + 1 + int'(req_delay_i)});
      end
      e_cnt = e_cnt + 1;
    end
  end

  function automatic logic [255:0] model_rel();
    logic [255:0] r;
    r = '0;
    foreach (toks[j]) begin
      if (toks[j].due <= e_cnt) r[toks[j].id] = 1'b1;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    cmp("model_ready", 256'(req_ready_o), 256'(toks.size() < NS));
    cmp("model_release", release_en_o, model_rel());
    cmp("model_outstanding", 256'(outstanding_o), 256'(toks.size()));
    cmp("model_err", 256'(err_o), 256'(m_err));
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic retire(input int id);
    rsp_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    rsp_id_i    = IDW'(id);
    tick();
    rsp_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic request(input int id, input int dly);
    req_valid_i = 1'b1;
    req_id_i    = IDW'(id);
    req_delay_i = DW'(dly);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_ready"}, 256'(req_ready_o), 256'(1));
    cmp({tag, "_release"}, release_en_o, 256'(0));
    cmp({tag, "_outstanding"}, 256'(outstanding_o), 256'(0));
    cmp({tag, "_err"}, 256'(err_o), 256'(0));
  endtask

  initial begin
    tick();
    tick();
    check_reset_vals("reset");
    rst_ni = 1'b1;
    tick();

    // Latency: delay 4 -> low for four cycles after acceptance, high on the fifth.
    request(3, 4);
    for (int k = 1; k <= 4; k++) begin
      cmp("lat4_low", 256'(release_en_o[3]), 256'(0));
      tick();
    end
    cmp("lat4_high", 256'(release_en_o[3]), 256'(1));
    retire(3);
    cmp("lat4_retired", 256'(outstanding_o), 256'(0));

    request(5, 0);
    cmp("lat0_high", 256'(release_en_o[5]), 256'(1));
    retire(5);
    cmp("lat0_retired", 256'(release_en_o[5]), 256'(0));

    // Two tokens on one ID: release stays up until the last is retired.
    req_valid_i = 1'b1;
    req_id_i    = 8'd7;
    req_delay_i = 8'd2;
    tick();
    tick();
    req_valid_i = 1'b0;
    repeat (3) tick();
    cmp("dup_out2", 256'(outstanding_o), 256'(2));
    cmp("dup_rel", 256'(release_en_o[7]), 256'(1));
    retire(7);
    cmp("dup_rel_after1", 256'(release_en_o[7]), 256'(1));
    cmp("dup_out1", 256'(outstanding_o), 256'(1));
    retire(7);
    cmp("dup_rel_after2", 256'(release_en_o[7]), 256'(0));
    cmp("dup_out0", 256'(outstanding_o), 256'(0));

    // Retire with no matured token: sticky error, pending token keeps its schedule.
    request(9, 3);
    retire(9);
    cmp("err_set", 256'(err_o), 256'(1));
    cmp("err_out", 256'(outstanding_o), 256'(1));
    cmp("err_rel_t2", 256'(release_en_o[9]), 256'(0));
    tick();
    cmp("err_rel_t3", 256'(release_en_o[9]), 256'(0));
    tick();
    cmp("err_rel_t4", 256'(release_en_o[9]), 256'(1));
    retire(9);
    cmp("err_sticky", 256'(err_o), 256'(1));

    // Fill every slot, then hold a 33rd request.
    for (int i = 0; i < NS; i++) request(i, 255);
    cmp("full_ready", 256'(req_ready_o), 256'(0));
    cmp("full_out", 256'(outstanding_o), 256'(32));
    req_valid_i = 1'b1;
    req_id_i    = 8'd40;
    req_delay_i = 8'd1;
    repeat (3) tick();
    cmp("stall_ready", 256'(req_ready_o), 256'(0));
    cmp("stall_out", 256'(outstanding_o), 256'(32));
    repeat (260) tick();
    cmp("full_matured", 256'(release_en_o[31:0]), 256'(32'hFFFF_FFFF));

    // Retire and request in the same cycle: freed slot is usable one cycle later.
    retire(1);
    cmp("simul_ready", 256'(req_ready_o), 256'(1));
    cmp("simul_out31", 256'(outstanding_o), 256'(31));
    cmp("simul_rel1", 256'(release_en_o[1]), 256'(0));
    tick();
    req_valid_i = 1'b0;
    cmp("simul_accept", 256'(outstanding_o), 256'(32));
    cmp("simul_full", 256'(req_ready_o), 256'(0));
    tick();
    cmp("simul_rel40", 256'(release_en_o[40]), 256'(1));

    rst_ni = 1'b0;
    #2;
    check_reset_vals("reset_full");
    tick();
    rst_ni = 1'b1;
    tick();

    // Mid-run reset with five pending tokens.
    for (int i = 0; i < 5; i++) request(20 + i, 10);
    cmp("pend5_out", 256'(outstanding_o), 256'(5));
    repeat (2) tick();
    rst_ni = 1'b0;
    #2;
    check_reset_vals("reset_mid");
    tick();
    rst_ni = 1'b1;
    repeat (15) tick();
    check_reset_vals("after_reset");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
